// File: rtl/wave_pkg.sv
// Shared constants, FSM encoding and sizing helper for the ADC0809 reader.
package wave_pkg;

    localparam int unsigned CLK_DIV_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF   = 1023;
    localparam int unsigned OE_CYCLES_DEF = 3;

    localparam int unsigned CH_W   = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_START,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_READ,
        ST_DONE
    } state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 1) return 1;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_div_toggle.sv
// Free-running toggle divider: output flips every HALF_PERIOD input clocks.
module clk_div_toggle
    import wave_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = CLK_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tgl
);

    localparam int unsigned CNT_W = cnt_width(HALF_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tgl;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_tgl <= 1'b0;
        end else if (r_cnt == CNT_W'(HALF_PERIOD - 1)) begin
            r_cnt <= '0;
            r_tgl <= ~r_tgl;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tgl = r_tgl;

endmodule

// File: rtl/adc0809_reader.sv
// ADC0809 conversion sequencer: latch channel, start, wait on EOC, read the
// bus and hand the code to a capture RAM with a wrapping write address.
module adc0809_reader
    import wave_pkg::*;
#(
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned OE_CYCLES = OE_CYCLES_DEF
) (
    input  logic              clk_5M,
    input  logic              rst,
    input  logic              en,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              ADC_EOC,
    input  logic [DATA_W-1:0] ADC_DATA,
    output logic              ADC_CLK,
    output logic [CH_W-1:0]   ADC_ADDR,
    output logic              ADC_ALE,
    output logic              ADC_START,
    output logic              ADC_OE,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned TCNT_W = cnt_width(TIMEOUT);
    localparam int unsigned OCNT_W = cnt_width(OE_CYCLES);

    state_e              r_state;
    logic                r_eoc_meta;
    logic                r_eoc_sync;
    logic                r_phase;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [OCNT_W-1:0]   r_ocnt;
    logic [CH_W-1:0]     r_addr;
    logic                r_ale;
    logic                r_start;
    logic                r_oe;
    logic [DATA_W-1:0]   r_sample;
    logic                r_sample_valid;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_busy;
    logic                r_timeout_err;

    logic [TCNT_W-1:0]   w_tcnt_next;
    logic                w_tcnt_hit;

    clk_div_toggle #(
        .HALF_PERIOD (CLK_DIV)
    ) u_clk_div (
        .i_clk (clk_5M),
        .i_rst (rst),
        .o_tgl (ADC_CLK)
    );

    // EOC arrives from the converter's own clock domain.
    always_ff @(posedge clk_5M) begin
        if (rst) begin
            r_eoc_meta <= 1'b0;
            r_eoc_sync <= 1'b0;
        end else begin
            r_eoc_meta <= ADC_EOC;
            r_eoc_sync <= r_eoc_meta;
        end
    end

    assign w_tcnt_next = r_tcnt + TCNT_W'(1);
    assign w_tcnt_hit  = (w_tcnt_next == TCNT_W'(TIMEOUT));

    always_ff @(posedge clk_5M) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_phase        <= 1'b0;
            r_tcnt         <= '0;
            r_ocnt         <= '0;
            r_addr         <= '0;
            r_ale          <= 1'b0;
            r_start        <= 1'b0;
            r_oe           <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_wr_addr      <= '0;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state <= ST_LATCH;
                        r_addr  <= ch_sel;
                        r_ale   <= 1'b1;
                        r_phase <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (r_phase) begin
                        r_state <= ST_START;
                        r_ale   <= 1'b0;
                        r_start <= 1'b1;
                        r_phase <= 1'b0;
                    end else begin
                        r_phase <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_phase) begin
                        r_state <= ST_WAIT_LOW;
                        r_start <= 1'b0;
                        r_phase <= 1'b0;
                        r_tcnt  <= '0;
                    end else begin
                        r_phase <= 1'b1;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!r_eoc_sync) begin
                        r_state <= ST_WAIT_HIGH;
                        r_tcnt  <= '0;
                    end else if (w_tcnt_hit) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (r_eoc_sync) begin
                        r_state <= ST_READ;
                        r_oe    <= 1'b1;
                        r_ocnt  <= '0;
                    end else if (w_tcnt_hit) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                    end
                end
                ST_READ: begin
                    // Bus is captured on the final OE cycle, after settling.
                    if (r_ocnt == OCNT_W'(OE_CYCLES - 1)) begin
                        r_state        <= ST_DONE;
                        r_oe           <= 1'b0;
                        r_sample       <= ADC_DATA;
                        r_sample_valid <= 1'b1;
                        r_wr_addr      <= r_wr_addr + ADDR_W'(1);
                    end else begin
                        r_ocnt <= r_ocnt + OCNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (en) begin
                        r_state <= ST_LATCH;
                        r_addr  <= ch_sel;
                        r_ale   <= 1'b1;
                        r_phase <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ale   <= 1'b0;
                    r_start <= 1'b0;
                    r_oe    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ADC_ADDR     = r_addr;
    assign ADC_ALE      = r_ale;
    assign ADC_START    = r_start;
    assign ADC_OE       = r_oe;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign wr_addr      = r_wr_addr;
    assign busy         = r_busy;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_adc0809_reader.sv
// Directed bench for adc0809_reader with a behavioural ADC0809 EOC model.
`timescale 1ns/1ps
module tb_adc0809_reader;

    logic        clk_5M = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  ch_sel;
    logic        ADC_EOC = 1'b1;
    logic [7:0]  ADC_DATA;
    logic        ADC_CLK;
    logic [2:0]  ADC_ADDR;
    logic        ADC_ALE;
    logic        ADC_START;
    logic        ADC_OE;
    logic [7:0]  sample;
    logic        sample_valid;
    logic [11:0] wr_addr;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // EOC model knobs
    logic eoc_stuck = 1'b0;
    int   eoc_lo    = 4;
    int   eoc_hi    = 40;

    // monitor state
    int   ale_run = 0, start_run = 0, oe_run = 0;
    int   last_ale = 0, last_start = 0, last_oe = 0;
    int   sv_count = 0, sv_double = 0, excl_viol = 0;
    logic sv_prev = 1'b0;

    adc0809_reader dut (
        .clk_5M       (clk_5M),
        .rst          (rst),
        .en           (en),
        .ch_sel       (ch_sel),
        .ADC_EOC      (ADC_EOC),
        .ADC_DATA     (ADC_DATA),
        .ADC_CLK      (ADC_CLK),
        .ADC_ADDR     (ADC_ADDR),
        .ADC_ALE      (ADC_ALE),
        .ADC_START    (ADC_START),
        .ADC_OE       (ADC_OE),
        .sample       (sample),
        .sample_valid (sample_valid),
        .wr_addr      (wr_addr),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #100 clk_5M = ~clk_5M;

    // Converter: EOC falls eoc_lo cycles after START ends, rises eoc_hi later.
    always begin
        @(negedge clk_5M iff ADC_START === 1'b1);
        @(negedge clk_5M iff ADC_START === 1'b0);
        if (!eoc_stuck) begin
            repeat (eoc_lo) @(negedge clk_5M);
            ADC_EOC = 1'b0;
            repeat (eoc_hi) @(negedge clk_5M);
            ADC_EOC = 1'b1;
        end
    end

    always @(negedge clk_5M) begin
        if ((32'(ADC_ALE) + 32'(ADC_START) + 32'(ADC_OE)) > 32'd1) excl_viol++;
        if (ADC_ALE === 1'b1) ale_run++;
        else begin if (ale_run != 0) last_ale = ale_run; ale_run = 0; end
        if (ADC_START === 1'b1) start_run++;
        else begin if (start_run != 0) last_start = start_run; start_run = 0; end
        if (ADC_OE === 1'b1) oe_run++;
        else begin if (oe_run != 0) last_oe = oe_run; oe_run = 0; end
        if (sample_valid === 1'b1) begin
            sv_count++;
            if (sv_prev) sv_double++;
        end
        sv_prev = (sample_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_5M);
    endtask

    task automatic wait_sv(input string tag, input int budget);
        int n;
        n = 0;
        while (sample_valid !== 1'b1 && n < budget) begin step(); n++; end
        check(tag, 32'(sample_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin step(); n++; end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #19_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wait_cycles, sv_before;
        rst = 1'b1; en = 1'b0; ch_sel = 3'd0; ADC_DATA = 8'h00;

        // Reset values, then free-running ADC_CLK with en low
        repeat (3) step();
        check("rst_clk",   32'(ADC_CLK), 32'd0);
        check("rst_addr",  32'(ADC_ADDR), 32'd0);
        check("rst_strb",  32'({ADC_ALE, ADC_START, ADC_OE}), 32'd0);
        check("rst_samp",  32'(sample), 32'd0);
        check("rst_sv",    32'(sample_valid), 32'd0);
        check("rst_wr",    32'(wr_addr), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_terr",  32'(timeout_err), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check("adc_clk", 32'(ADC_CLK), 32'((i / 4) % 2));
        end
        check("idle_busy", 32'(busy), 32'd0);

        // Single conversion on channel 3, en dropped once LATCH is entered
        ADC_DATA = 8'hA5; ch_sel = 3'd3; en = 1'b1;
        step();
        check("b_busy", 32'(busy), 32'd1);
        check("b_addr", 32'(ADC_ADDR), 32'd3);
        check("b_ale",  32'(ADC_ALE), 32'd1);
        en = 1'b0;
        wait_sv("b_sv_seen", 200);
        check("b_sample", 32'(sample), 32'hA5);
        check("b_wr",     32'(wr_addr), 32'd1);
        step();
        check("b_sv_one",  32'(sample_valid), 32'd0);
        check("b_idle",    32'(busy), 32'd0);
        check("b_ale_len", 32'(last_ale), 32'd2);
        check("b_st_len",  32'(last_start), 32'd2);
        check("b_oe_len",  32'(last_oe), 32'd3);
        check("b_sv_cnt",  32'(sv_count), 32'd1);

        // EOC never falls: timeout after 1023 WAIT_LOW cycles
        check("c_terr_pre", 32'(timeout_err), 32'd0);
        eoc_stuck = 1'b1; sv_before = sv_count; ADC_DATA = 8'hFF;
        en = 1'b1;
        step();
        en = 1'b0;
        n = 0; wait_cycles = 0;
        while (busy === 1'b1 && n < 1200) begin
            step(); n++;
            if (busy === 1'b1 && !ADC_ALE && !ADC_START && !ADC_OE) wait_cycles++;
        end
        check("c_wait_len", 32'(wait_cycles), 32'd1023);
        check("c_terr",     32'(timeout_err), 32'd1);
        check("c_idle",     32'(busy), 32'd0);
        check("c_sample",   32'(sample), 32'hA5);
        check("c_wr",       32'(wr_addr), 32'd1);
        check("c_no_sv",    32'(sv_count), 32'(sv_before));

        // en dropped in WAIT_HIGH, ch_sel 1 -> 6 mid-conversion
        eoc_stuck = 1'b0; ADC_DATA = 8'h3C; ch_sel = 3'd1; en = 1'b1;
        step();
        check("d_addr1", 32'(ADC_ADDR), 32'd1);
        n = 0;
        while (ADC_EOC !== 1'b0 && n < 100) begin step(); n++; end
        check("d_eoc_low", 32'(ADC_EOC), 32'd0);
        repeat (5) step();
        en = 1'b0; ch_sel = 3'd6;
        wait_sv("d_sv_seen", 200);
        check("d_sample", 32'(sample), 32'h3C);
        check("d_addr_kept", 32'(ADC_ADDR), 32'd1);
        check("d_wr", 32'(wr_addr), 32'd2);
        step();
        check("d_idle", 32'(busy), 32'd0);
        check("d_terr_sticky", 32'(timeout_err), 32'd1);
        en = 1'b1;
        step();
        check("d_addr6", 32'(ADC_ADDR), 32'd6);
        check("d_ale6",  32'(ADC_ALE), 32'd1);
        en = 1'b0;
        wait_sv("d_sv2_seen", 200);
        check("d_wr2", 32'(wr_addr), 32'd3);
        step();

        // Reset during the second OE cycle
        ADC_DATA = 8'h77; en = 1'b1;
        step();
        en = 1'b0;
        n = 0;
        while (ADC_OE !== 1'b1 && n < 200) begin step(); n++; end
        check("e_oe1", 32'(ADC_OE), 32'd1);
        step();
        check("e_oe2", 32'(ADC_OE), 32'd1);
        rst = 1'b1; sv_before = sv_count;
        step();
        rst = 1'b0;
        check("e_oe_drop", 32'(ADC_OE), 32'd0);
        check("e_sample",  32'(sample), 32'd0);
        check("e_sv",      32'(sample_valid), 32'd0);
        check("e_wr",      32'(wr_addr), 32'd0);
        check("e_busy",    32'(busy), 32'd0);
        check("e_terr",    32'(timeout_err), 32'd0);
        check("e_addr",    32'(ADC_ADDR), 32'd0);
        check("e_clk",     32'(ADC_CLK), 32'd0);
        repeat (10) step();
        check("e_no_sv", 32'(sv_count), 32'(sv_before));
        check("e_still_idle", 32'(busy), 32'd0);

        // Recovery plus 4097 back-to-back conversions: wr_addr wraps 4095 -> 0 -> 1
        eoc_lo = 1; eoc_hi = 2; ADC_DATA = 8'h5A; ch_sel = 3'd2;
        sv_before = sv_count; en = 1'b1;
        for (int k = 1; k <= 4097; k++) begin
            wait_sv("f_sv_seen", 100);
            check("f_wr", 32'(wr_addr), 32'(k % 4096));
            if (k == 1) begin
                check("f_sample", 32'(sample), 32'h5A);
                check("f_addr",   32'(ADC_ADDR), 32'd2);
            end
            step();
        end
        check("f_sv_total", 32'(sv_count - sv_before), 32'd4097);
        en = 1'b0;
        wait_idle("f_idle", 100);
        check("f_wr_final", 32'(wr_addr), 32'd2);
        check("f_excl",     32'(excl_viol), 32'd0);
        check("f_sv_width", 32'(sv_double), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
